// File: rtl/imem_pkg.sv
// Shared definitions for the byte-wide big-endian instruction memory,
// its write-side loader and the fetch stage.
package imem_pkg;

  localparam int IMEM_BYTES     = 4096;
  localparam int BYTES_PER_WORD = 4;
  localparam int IMEM_ADDR_W    = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Word stream into the loader and byte write port out of it toward the
// instruction memory.
interface imem_loader_if;

  // Word stream: a word transfers on a rising clk edge where word_valid and
  // word_ready are both 1. The source holds word_data/word_last stable while
  // word_valid is 1 and ready is 0; ready never depends on valid.
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_last;
  logic        word_ready;

  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;

  modport master (
    output word_valid, word_data, word_last,
    input  word_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  word_valid, word_data, word_last,
    output word_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_loader.sv
// Accepts 32-bit instruction words and writes each as four bytes, MSB at the
// lowest address, through an auto-incrementing byte pointer.
module imem_loader
  import imem_pkg::*;
#(
  parameter int MEM_BYTES = IMEM_BYTES,
  parameter int ADDR_W    = IMEM_ADDR_W,
  parameter int CNT_W     = 11
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [31:0]      start_addr,
  imem_loader_if.slave     bus,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] word_count,
  output logic             overflow,
  output loader_state_t    state
);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [1:0]        byte_idx_q;
  logic [31:0]       word_q;
  logic              last_q;
  logic [CNT_W-1:0]  count_q;
  logic              ovf_q;

  logic [ADDR_W:0]   ptr_sum;
  logic [ADDR_W-1:0] wr_addr;
  logic              word_ready;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [7:0]        mem_wdata;
  logic              unused_addr_bits;

  // Only the in-memory, word-aligned part of start_addr is meaningful.
  assign unused_addr_bits = ^{start_addr[31:ADDR_W], start_addr[1:0]};

  // One extra bit so a wrap past the top of memory is visible as a carry.
  assign ptr_sum = {1'b0, ptr_q} + (ADDR_W+1)'(BYTES_PER_WORD);
  assign wr_addr = ptr_q + ADDR_W'(byte_idx_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    word_ready = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = {{(32-ADDR_W){1'b0}}, ptr_q};
    mem_wdata  = 8'h00;
    case (state_q)
      IDLE: begin
        if (start) state_d = ACCEPT;
      end
      ACCEPT: begin
        word_ready = 1'b1;
        if (bus.word_valid) state_d = WRITE;
      end
      WRITE: begin
        mem_we   = 1'b1;
        mem_addr = {{(32-ADDR_W){1'b0}}, wr_addr};
        case (byte_idx_q)
          2'd0:    mem_wdata = word_q[31:24];
          2'd1:    mem_wdata = word_q[23:16];
          2'd2:    mem_wdata = word_q[15:8];
          default: mem_wdata = word_q[7:0];
        endcase
        if (byte_idx_q == 2'd3) state_d = last_q ? DONE : ACCEPT;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q      <= '0;
      byte_idx_q <= 2'd0;
      word_q     <= 32'h0;
      last_q     <= 1'b0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            ptr_q   <= {start_addr[ADDR_W-1:2], 2'b00};
            count_q <= '0;
            ovf_q   <= 1'b0;
          end
        end
        ACCEPT: begin
          if (bus.word_valid) begin
            word_q     <= bus.word_data;
            last_q     <= bus.word_last;
            byte_idx_q <= 2'd0;
          end
        end
        WRITE: begin
          byte_idx_q <= byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            ptr_q   <= ptr_sum[ADDR_W-1:0];
            count_q <= count_q + CNT_W'(1);
            // Sticky: loading carries on from address 0 after a wrap.
            if (ptr_sum >= (ADDR_W+1)'(MEM_BYTES)) ovf_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.word_ready = word_ready;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign word_count = count_q;
  assign overflow   = ovf_q;
  assign state      = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: fixed scenarios plus randomized sessions, checked
// against a byte-address model of the expected memory writes.
module tb_imem_loader;
  import imem_pkg::*;

  localparam int MEM = IMEM_BYTES;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   start_addr = 32'h0;
  logic          busy, done, overflow;
  logic [10:0]   word_count;
  loader_state_t state;

  imem_loader_if bus();

  imem_loader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .start_addr (start_addr),
    .bus        (bus.slave),
    .busy       (busy),
    .done       (done),
    .word_count (word_count),
    .overflow   (overflow),
    .state      (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  // ---------------- scoreboard ----------------
  logic [31:0] tx_q[$];
  logic [39:0] exp_q[$];
  logic [39:0] obs_q[$];
  int          obs_cyc_q[$];
  int          done_q[$];
  int          hs_q[$];
  int          ready_bad = 0;
  logic [10:0] exp_cnt;
  logic        exp_ovf;

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.mem_we) begin
        obs_q.push_back({bus.mem_addr, bus.mem_wdata});
        obs_cyc_q.push_back(cyc);
      end
      if (done) done_q.push_back(cyc);
      if (bus.word_ready && (bus.mem_we || done || !busy)) ready_bad++;
    end
  end

  // Reference: word i of a session lands at aligned base + 4*i (mod MEM),
  // big-endian; overflow if any word ends at or past the top of memory.
  function automatic void build_expected(input logic [31:0] addr);
    int base;
    logic [31:0] w;
    base = int'({addr[11:2], 2'b00});
    exp_q.delete();
    for (int i = 0; i < tx_q.size(); i++) begin
      for (int k = 0; k < 4; k++) begin
        w = tx_q[i] >> (8 * (3 - k));
        exp_q.push_back({32'((base + 4 * i + k) % MEM), w[7:0]});
      end
    end
    exp_cnt = 11'(tx_q.size() % 2048);
    exp_ovf = (base + 4 * tx_q.size()) >= MEM;
  endfunction

  // ---------------- drivers ----------------
  task automatic do_start(input logic [31:0] addr);
    start = 1'b1;
    start_addr = addr;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for 'gap' idle ACCEPT cycles, then offers the word until taken.
  // hs is the clock-edge number on which the handshake happens.
  task automatic send_word(input logic [31:0] d, input logic l, input int gap, output int hs);
    int t;
    int g;
    t = 0;
    g = gap;
    hs = -1;
    while (g > 0 && t < 50) begin
      if (bus.word_ready) g--;
      @(negedge clk);
      t++;
    end
    bus.word_valid = 1'b1;
    bus.word_data = d;
    bus.word_last = l;
    forever begin
      if (bus.word_ready) begin
        hs = cyc + 1;
        @(negedge clk);
        break;
      end
      if (t >= 100) break;
      @(negedge clk);
      t++;
    end
    bus.word_valid = 1'b0;
    bus.word_data = $urandom;
    bus.word_last = 1'($urandom_range(0, 1));
    if (hs < 0) begin
      checks++;
      $display("FAIL handshake_timeout: word %h not accepted within %0d cycles, required acceptance", d, t);
    end
  endtask

  task automatic run_session(input logic [31:0] addr, input int min_gap, input int max_gap, input bit poke);
    int hs;
    int t;
    obs_q.delete();
    obs_cyc_q.delete();
    done_q.delete();
    hs_q.delete();
    ready_bad = 0;
    build_expected(addr);
    do_start(addr);
    foreach (tx_q[i]) begin
      send_word(tx_q[i], i == tx_q.size() - 1, $urandom_range(max_gap, min_gap), hs);
      hs_q.push_back(hs);
      if (poke && i == 0) begin
        start = 1'b1;
        start_addr = 32'h100;
        @(negedge clk);
        start = 1'b0;
        start_addr = addr;
      end
    end
    t = 0;
    while (!done && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    if (t >= 20) begin
      checks++;
      $display("FAIL done_timeout: done not seen within 20 cycles of last word, required a pulse");
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int hs;
    bus.word_valid = 1'b0;
    bus.word_data = 32'h0;
    bus.word_last = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.mem_we, bus.word_ready, busy, done, overflow} !== 5'b0)
      $display("FAIL reset_flags: we/rdy/busy/done/ovf=%b required 00000",
               {bus.mem_we, bus.word_ready, busy, done, overflow});
    else passes++;
    checks++;
    if (word_count !== 11'd0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 8'h0 || state !== IDLE)
      $display("FAIL reset_values: count=%0d addr=%h wdata=%h state=%0d required 0/0/0/IDLE",
               word_count, bus.mem_addr, bus.mem_wdata, state);
    else passes++;
    reset_n = 1'b1;
    @(negedge clk);

    do_start(32'h200);
    send_word(32'hDEADBEEF, 1'b0, 0, hs);
    @(negedge clk);
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h201 || bus.mem_wdata !== 8'hAD)
      $display("FAIL reset_pre_byte1: we=%b addr=%h data=%h required 1/00000201/ad",
               bus.mem_we, bus.mem_addr, bus.mem_wdata);
    else passes++;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_we, busy, bus.word_ready} !== 3'b000)
      $display("FAIL reset_async: we/busy/rdy=%b required 000 before any clock edge",
               {bus.mem_we, busy, bus.word_ready});
    else passes++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== IDLE || word_count !== 11'd0 || busy !== 1'b0)
      $display("FAIL reset_after: state=%0d count=%0d busy=%b required IDLE/0/0", state, word_count, busy);
    else passes++;
  endtask

  task automatic test_single_word();
    tx_q.delete();
    tx_q.push_back(32'h8C220004);
    run_session(32'h0, 0, 0, 1'b0);
    checks++;
    if (obs_q.size() != 4) $display("FAIL single_nwrites: got %0d required 4", obs_q.size());
    else passes++;
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i] || obs_cyc_q[i] != hs_q[i / 4] + i % 4)
        $display("FAIL single_write[%0d]: got %h required %h one cycle after handshake + byte index",
                 i, (i < obs_q.size()) ? obs_q[i] : 40'h0, exp_q[i]);
      else passes++;
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] != hs_q[0] + 4)
      $display("FAIL single_done: pulses=%0d at=%0d required 1 at %0d", done_q.size(),
               (done_q.size() > 0) ? done_q[0] : -1, hs_q[0] + 4);
    else passes++;
    checks++;
    if (word_count !== 11'd1 || overflow !== 1'b0 || busy !== 1'b0)
      $display("FAIL single_status: count=%0d ovf=%b busy=%b required 1/0/0", word_count, overflow, busy);
    else passes++;
  endtask

  task automatic test_gaps();
    tx_q.delete();
    tx_q.push_back(32'h20010005);
    tx_q.push_back(32'h00221820);
    tx_q.push_back(32'hAC030000);
    run_session(32'h10, 2, 2, 1'b0);
    checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL gaps_nwrites: got %0d required %0d", obs_q.size(), exp_q.size());
    else passes++;
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i] || obs_cyc_q[i] != hs_q[i / 4] + i % 4)
        $display("FAIL gaps_write[%0d]: got %h required %h", i, (i < obs_q.size()) ? obs_q[i] : 40'h0, exp_q[i]);
      else passes++;
    end
    checks++;
    if (ready_bad != 0) $display("FAIL gaps_ready: word_ready outside ACCEPT %0d times, required 0", ready_bad);
    else passes++;
    checks++;
    if (word_count !== 11'd3 || overflow !== 1'b0 || done_q.size() != 1)
      $display("FAIL gaps_status: count=%0d ovf=%b dones=%0d required 3/0/1", word_count, overflow, done_q.size());
    else passes++;
  endtask

  task automatic test_wrap();
    tx_q.delete();
    tx_q.push_back(32'h11223344);
    tx_q.push_back(32'h55667788);
    run_session(32'h00000FFE, 0, 1, 1'b0);
    checks++;
    if (obs_q.size() != 8) $display("FAIL wrap_nwrites: got %0d required 8", obs_q.size());
    else passes++;
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i] || obs_cyc_q[i] != hs_q[i / 4] + i % 4)
        $display("FAIL wrap_write[%0d]: got %h required %h", i, (i < obs_q.size()) ? obs_q[i] : 40'h0, exp_q[i]);
      else passes++;
    end
    checks++;
    if (overflow !== 1'b1 || word_count !== 11'd2)
      $display("FAIL wrap_status: ovf=%b count=%0d required 1/2", overflow, word_count);
    else passes++;
  endtask

  task automatic test_start_ignored();
    tx_q.delete();
    tx_q.push_back(32'hA5B6C7D8);
    tx_q.push_back(32'h0F1E2D3C);
    run_session(32'h40, 0, 1, 1'b1);
    checks++;
    if (obs_q.size() != 8) $display("FAIL busy_start_nwrites: got %0d required 8", obs_q.size());
    else passes++;
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
        $display("FAIL busy_start_write[%0d]: got %h required %h", i, (i < obs_q.size()) ? obs_q[i] : 40'h0, exp_q[i]);
      else passes++;
    end
    checks++;
    if (word_count !== 11'd2 || done_q.size() != 1 || state !== IDLE)
      $display("FAIL busy_start_status: count=%0d dones=%0d state=%0d required 2/1/IDLE",
               word_count, done_q.size(), state);
    else passes++;
  endtask

  task automatic test_random();
    logic [31:0] addr;
    for (int s = 0; s < 10; s++) begin
      tx_q.delete();
      repeat ($urandom_range(1, 6)) tx_q.push_back($urandom);
      addr = $urandom;
      if (s % 2 == 0) addr[11:0] = 12'($urandom_range(4064, 4095));
      run_session(addr, 0, 3, 1'($urandom_range(0, 1)));
      checks++;
      if (obs_q.size() != exp_q.size())
        $display("FAIL rand%0d_nwrites: got %0d required %0d", s, obs_q.size(), exp_q.size());
      else passes++;
      foreach (exp_q[i]) begin
        checks++;
        if (i >= obs_q.size() || obs_q[i] !== exp_q[i] || obs_cyc_q[i] != hs_q[i / 4] + i % 4)
          $display("FAIL rand%0d_write[%0d]: got %h required %h", s, i,
                   (i < obs_q.size()) ? obs_q[i] : 40'h0, exp_q[i]);
        else passes++;
      end
      checks++;
      if (word_count !== exp_cnt || overflow !== exp_ovf || ready_bad != 0 ||
          done_q.size() != 1 || done_q[0] != hs_q[hs_q.size() - 1] + 4)
        $display("FAIL rand%0d_status: count=%0d ovf=%b badrdy=%0d dones=%0d required %0d/%b/0/1",
                 s, word_count, overflow, ready_bad, done_q.size(), exp_cnt, exp_ovf);
      else passes++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    @(negedge clk);
    test_reset();
    test_single_word();
    test_gaps();
    test_wrap();
    test_start_ignored();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench still running at %0t, required to have finished", $time);
    $fatal(1);
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion of the byte-wide, big-endian instruction memory.
- Accepts 32-bit instruction words over a valid/ready stream from the testbench or boot path.
- Serialises each word into four byte writes at consecutive addresses, most significant byte at the lowest address, with an auto-incrementing pointer.
- Sits between the program source and the memory's write port; the fetch path reads the result back as {mem[a],mem[a+1],mem[a+2],mem[a+3]}.

Parameters:
- MEM_BYTES, 4096, memory depth in bytes; power of two.
- ADDR_W, 12, log2(MEM_BYTES); width of the internal byte pointer.
- CNT_W, 11, width of word_count; wraps modulo 2^CNT_W.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a load session; sampled only in IDLE.
- start_addr  in  32  byte address of the first word; bits[1:0] forced to 0, bits above ADDR_W-1 ignored.
- word_valid  in  1  word_data/word_last valid.
- word_data  in  32  instruction word.
- word_last  in  1  marks final word of session.
- word_ready  out  1  loader accepts a word this cycle.
- mem_we  out  1  byte write strobe.
- mem_addr  out  32  byte address, zero-extended from ADDR_W.
- mem_wdata  out  8  byte to write.
- busy  out  1  session in progress (not IDLE).
- done  out  1  one-cycle pulse at session end.
- word_count  out  CNT_W  words fully written in current/last session.
- overflow  out  1  sticky: pointer wrapped past MEM_BYTES-1 during session.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; all outputs 0; pointer 0; any partial word abandoned; mem_we drops without waiting for a clock edge.
- FSM states: IDLE, ACCEPT, WRITE, DONE.
- IDLE:
  - word_ready=0, mem_we=0, busy=0.
  - On start=1: pointer←start_addr[ADDR_W-1:0] with [1:0]=0; word_count←0; overflow←0; go to ACCEPT.
- ACCEPT:
  - word_ready=1, busy=1.
  - On word_valid&word_ready: capture word_data and word_last, byte_idx←0, go to WRITE.
  - No timeout; the loader waits indefinitely.
- WRITE:
  - Lasts 4 cycles, byte_idx 0..3; word_ready=0; mem_we=1.
  - mem_addr = pointer + byte_idx.
  - mem_wdata = word[31-8*byte_idx -: 8], so byte 0 = bits[31:24].
  - At byte_idx=3 edge: pointer←(pointer+4) mod MEM_BYTES; word_count←word_count+1.
  - If pointer+4 ≥ MEM_BYTES, set overflow=1 and keep loading.
  - Next state is DONE if the captured last flag is 1, else ACCEPT.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE. word_count and overflow hold until the next start.
- Throughput and latency: 5 cycles per word (1 accept + 4 writes). First mem_we appears in the cycle after the accepting handshake.
- Outputs outside WRITE: mem_we=0, mem_wdata=0, mem_addr=pointer.
- start while busy: ignored, with no effect on the session.
- word_valid outside ACCEPT: not consumed; the source must hold data until ready, per the standard valid/ready rule.
- Unaligned start_addr (e.g. 0x...3): treated as the aligned address 0x...0.
- Wrap example: pointer=0xFFC writes 0xFFC..0xFFF, then the next word goes to 0x000.

Decomposition:
- Shared package imem_pkg holds:
  - loader_state_t enum {IDLE, ACCEPT, WRITE, DONE};
  - IMEM_BYTES=4096;
  - BYTES_PER_WORD=4;
  - IMEM_ADDR_W=12.
  - The instruction memory and the fetch stage reuse these.
- Single module. The word-to-byte serialiser (byte_idx counter plus lane mux) is inline; no sub-module is warranted.

Test Plan:
- Reset mid-WRITE (reset_n low during byte_idx=1) -> mem_we, busy, word_ready fall to 0 immediately; after release, state is IDLE and word_count=0.
- start_addr=0x0, one word 0x8C220004 with last=1 -> writes 0x8C@0, 0x22@1, 0x00@2, 0x04@3 on 4 consecutive cycles; done pulses one cycle later; word_count=1; overflow=0.
- start_addr=0x10, 3 words (0x20010005, 0x00221820, 0xAC030000), source dropping word_valid for 2 cycles between words -> bytes land at 0x10..0x1B big-endian; word_ready high only in ACCEPT; word_count=3.
- start_addr=0xFFE (unaligned, near top), 2 words -> first word at 0xFFC..0xFFF, second at 0x000..0x003; overflow=1; word_count=2.
- start pulsed during WRITE with different start_addr=0x100 -> ignored; session continues at the original pointer and completes unchanged.
